// File: rtl/axi4l_master_bridge_pkg.sv
// Shared types for the register-bus to AXI4-Lite initiator bridge.
package axi4l_master_bridge_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } bridge_state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // Anything other than OKAY, EXOKAY included, is reported as an error.
  function automatic logic isErrResp(input logic [1:0] resp);
    return axi4l_resp_t'(resp) != OKAY;
  endfunction

endpackage

// File: rtl/axi4l_master_bridge_if.sv
// AXI4-Lite bus bundle; the bridge uses the master side, slaves the slave side.
interface axi4l_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4l_master_bridge.sv
// Register-bus to AXI4-Lite initiator: one command in, one AXI4-Lite write or read out,
// completion reported as a one-cycle ack with err/rdata. One outstanding transaction.
module axi4l_master_bridge
  import axi4l_master_bridge_pkg::*;
#(
  parameter int                        REG_ADDR_WIDTH = 16,
  parameter int                        REG_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = AXI_ADDR_WIDTH'(32'h8000_0000),
  parameter int                        TIMEOUT_CYCLES = 1024
) (
  input  logic                        axi4l_aclk,
  input  logic                        axi4l_arstn,
  input  logic                        reg_req,
  input  logic                        reg_wren,
  input  logic [REG_ADDR_WIDTH-1:0]   reg_addr,
  input  logic [REG_DATA_WIDTH-1:0]   reg_wdata,
  input  logic [REG_DATA_WIDTH/8-1:0] reg_be,
  output logic [REG_DATA_WIDTH-1:0]   reg_rdata,
  output logic                        reg_ack,
  output logic                        reg_err,
  output logic                        busy,
  output logic                        timeout,
  axi4l_master_bridge_if.master       m_axi
);

  if (REG_DATA_WIDTH != AXI_DATA_WIDTH) begin : gBadDataWidth
    $fatal(1, "axi4l_master_bridge: REG_DATA_WIDTH must equal AXI_DATA_WIDTH");
  end
  if (AXI_ADDR_WIDTH < REG_ADDR_WIDTH) begin : gBadAddrWidth
    $fatal(1, "axi4l_master_bridge: AXI_ADDR_WIDTH must be >= REG_ADDR_WIDTH");
  end

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~((AXI_ADDR_WIDTH'(1) << ADDR_LSB) - AXI_ADDR_WIDTH'(1));
  localparam int WDOG_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES);

  bridge_state_t               state_q, state_d;
  logic                        awValid_q, awValid_d, wValid_q, wValid_d;
  logic                        bReady_q, bReady_d, arValid_q, arValid_d, rReady_q, rReady_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH/8-1:0] be_q, be_d;
  logic                        errCap_q, errCap_d, ack_q, ack_d, err_q, err_d;
  logic                        timeout_q, timeout_d;
  logic [WDOG_WIDTH-1:0]       wdog_q, wdog_d;
  logic                        accept, waiting;

  // A new command is only taken when nothing is in flight and no ack is pending.
  assign accept  = reg_req && (state_q == IDLE) && !ack_q;
  assign waiting = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

  always_ff @(posedge axi4l_aclk or posedge axi4l_arstn) begin
    if (axi4l_arstn) begin
      state_q   <= IDLE;
      awValid_q <= 1'b0;
      wValid_q  <= 1'b0;
      bReady_q  <= 1'b0;
      arValid_q <= 1'b0;
      rReady_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      errCap_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      awValid_q <= awValid_d;
      wValid_q  <= wValid_d;
      bReady_q  <= bReady_d;
      arValid_q <= arValid_d;
      rReady_q  <= rReady_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      errCap_q  <= errCap_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  // AW and W valids double as the "still outstanding" flags, so either order of accept works.
  always_comb begin
    state_d   = state_q;
    awValid_d = awValid_q;
    wValid_d  = wValid_q;
    bReady_d  = bReady_q;
    arValid_d = arValid_q;
    rReady_d  = rReady_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    errCap_d  = errCap_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = (AXI_BASE_ADDR | AXI_ADDR_WIDTH'(reg_addr)) & ALIGN_MASK;
          wdata_d = reg_wdata;
          be_d    = reg_be;
          if (reg_wren) begin
            state_d   = WR_REQ;
            awValid_d = 1'b1;
            wValid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arValid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (m_axi.awready) awValid_d = 1'b0;
        if (m_axi.wready)  wValid_d  = 1'b0;
        if (!awValid_d && !wValid_d) begin
          state_d  = WR_RESP;
          bReady_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid && bReady_q) begin
          errCap_d = isErrResp(m_axi.bresp);
          bReady_d = 1'b0;
          state_d  = DONE;
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          arValid_d = 1'b0;
          rReady_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid && rReady_q) begin
          rdata_d  = m_axi.rdata;
          errCap_d = isErrResp(m_axi.rresp);
          rReady_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Watchdog restarts on every state change and only flags; the transaction keeps waiting.
  always_comb begin
    wdog_d    = '0;
    timeout_d = timeout_q;
    ack_d     = (state_q == DONE);
    err_d     = (state_q == DONE) && errCap_q;
    if ((TIMEOUT_CYCLES != 0) && waiting && (state_d == state_q)) begin
      wdog_d = (wdog_q == WDOG_LIMIT) ? wdog_q : wdog_q + WDOG_WIDTH'(1);
      if (wdog_d == WDOG_LIMIT) timeout_d = 1'b1;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ack   = ack_q;
  assign reg_err   = err_q;
  assign busy      = (state_q != IDLE) || ack_q;
  assign timeout   = timeout_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT_DEFAULT;
  assign m_axi.awvalid = awValid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = be_q;
  assign m_axi.wvalid  = wValid_q;
  assign m_axi.bready  = bReady_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT_DEFAULT;
  assign m_axi.arvalid = arValid_q;
  assign m_axi.rready  = rReady_q;

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Bench for axi4l_master_bridge: a table of directed commands against an AXI4-Lite slave
// model with programmable ready/valid delays, plus hand sequences for the multi-cycle cases.
module tb_axi4l_master_bridge;
  import axi4l_master_bridge_pkg::*;

  localparam int TIMEOUT = 1024;

  logic        aclk;
  logic        arst;
  logic        regReq;
  logic        regWren;
  logic [15:0] regAddr;
  logic [31:0] regWdata;
  logic [3:0]  regBe;
  logic [31:0] regRdata;
  logic        regAck;
  logic        regErr;
  logic        busy;
  logic        timeout;

  axi4l_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4l_master_bridge #(
    .REG_ADDR_WIDTH(16),
    .REG_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .AXI_BASE_ADDR (32'h8000_0000),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .axi4l_aclk (aclk),
    .axi4l_arstn(arst),
    .reg_req    (regReq),
    .reg_wren   (regWren),
    .reg_addr   (regAddr),
    .reg_wdata  (regWdata),
    .reg_be     (regBe),
    .reg_rdata  (regRdata),
    .reg_ack    (regAck),
    .reg_err    (regErr),
    .busy       (busy),
    .timeout    (timeout),
    .m_axi      (bus.master)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave model configuration, written only by the stimulus process.
  int          awDelay, wDelay, bDelay, arDelay, rDelay;
  logic [1:0]  bRespCfg, rRespCfg;

  // Slave model state.
  logic [31:0] mem [0:15];
  int          awCnt, wCnt, bCnt, arCnt, rCnt;
  logic        gotAw, gotW, pendB, pendR;
  logic [31:0] awAddrL, wDataL;
  logic [3:0]  wStrbL, rIdx;
  logic [31:0] lastAwAddr, lastArAddr;
  logic [3:0]  lastWStrb;
  int          awBeats, wBeats, arBeats;

  assign bus.awready = bus.awvalid && (awCnt >= awDelay);
  assign bus.wready  = bus.wvalid && (wCnt >= wDelay);
  assign bus.bvalid  = pendB && (bCnt >= bDelay);
  assign bus.bresp   = bRespCfg;
  assign bus.arready = bus.arvalid && (arCnt >= arDelay);
  assign bus.rvalid  = pendR && (rCnt >= rDelay);
  assign bus.rdata   = mem[rIdx];
  assign bus.rresp   = rRespCfg;

  // Slave: readies/valids appear after the configured number of wait cycles.
  always @(posedge aclk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[2] <= 32'h0000_FFFF;
      {awCnt, wCnt, bCnt, arCnt, rCnt} <= '0;
      {gotAw, gotW, pendB, pendR} <= '0;
      awAddrL <= '0; wDataL <= '0; wStrbL <= '0; rIdx <= '0;
    end else begin
      awCnt <= (bus.awvalid && !bus.awready) ? awCnt + 1 : 0;
      wCnt  <= (bus.wvalid && !bus.wready) ? wCnt + 1 : 0;
      arCnt <= (bus.arvalid && !bus.arready) ? arCnt + 1 : 0;
      if (bus.awvalid && bus.awready) begin
        gotAw <= 1'b1; awAddrL <= bus.awaddr; lastAwAddr <= bus.awaddr; awBeats <= awBeats + 1;
      end
      if (bus.wvalid && bus.wready) begin
        gotW <= 1'b1; wDataL <= bus.wdata; wStrbL <= bus.wstrb; lastWStrb <= bus.wstrb; wBeats <= wBeats + 1;
      end
      if ((gotAw || (bus.awvalid && bus.awready)) && (gotW || (bus.wvalid && bus.wready))) begin
        gotAw <= 1'b0; gotW <= 1'b0; pendB <= 1'b1; bCnt <= 0;
      end
      if (pendB && !bus.bvalid) bCnt <= bCnt + 1;
      if (bus.bvalid && bus.bready) begin
        pendB <= 1'b0;
        if (bRespCfg == 2'b00)
          for (int b = 0; b < 4; b++)
            if (wStrbL[b]) mem[awAddrL[5:2]][8*b +: 8] <= wDataL[8*b +: 8];
      end
      if (bus.arvalid && bus.arready) begin
        pendR <= 1'b1; rCnt <= 0; rIdx <= bus.araddr[5:2]; lastArAddr <= bus.araddr; arBeats <= arBeats + 1;
      end
      if (pendR && !bus.rvalid) rCnt <= rCnt + 1;
      if (bus.rvalid && bus.rready) pendR <= 1'b0;
    end
  end

  // Payload-stability monitor: a valid that was not accepted must hold with unchanged payload.
  int          stabViol = 0;
  logic        holdAw, holdW, holdAr;
  logic [31:0] heldAwAddr, heldWData, heldArAddr;
  logic [3:0]  heldWStrb;
  always @(posedge aclk or posedge arst) begin
    if (arst) begin
      {holdAw, holdW, holdAr} <= '0;
    end else begin
      if (holdAw && (!bus.awvalid || bus.awaddr != heldAwAddr)) stabViol <= stabViol + 1;
      if (holdW && (!bus.wvalid || bus.wdata != heldWData || bus.wstrb != heldWStrb)) stabViol <= stabViol + 1;
      if (holdAr && (!bus.arvalid || bus.araddr != heldArAddr)) stabViol <= stabViol + 1;
      holdAw <= bus.awvalid && !bus.awready; heldAwAddr <= bus.awaddr;
      holdW  <= bus.wvalid && !bus.wready;   heldWData  <= bus.wdata; heldWStrb <= bus.wstrb;
      holdAr <= bus.arvalid && !bus.arready; heldArAddr <= bus.araddr;
    end
  end

  typedef struct {
    logic        wren;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          awD, wD, bD, arD, rD;
    logic [1:0]  bresp, rresp;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
  } vector_t;

  vector_t vectors [10];
  int      checks = 0;
  int      errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issues one command and waits (bounded) for its ack; lat counts cycles after the request cycle.
  task automatic applyStimulus(input vector_t v, output int lat, output logic ackHigh,
                               output logic ackErr, output logic [31:0] ackRdata);
    awDelay = v.awD; wDelay = v.wD; bDelay = v.bD; arDelay = v.arD; rDelay = v.rD;
    bRespCfg = v.bresp; rRespCfg = v.rresp;
    regWren = v.wren; regAddr = v.addr; regWdata = v.wdata; regBe = v.be;
    regReq = 1'b1;
    @(posedge aclk); #1;
    regReq = 1'b0;
    lat = 1;
    while (!regAck && lat < 2000) begin
      @(posedge aclk); #1;
      lat++;
    end
    ackHigh = regAck; ackErr = regErr; ackRdata = regRdata;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit: got no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int          lat, n, ackCount;
    int          awBefore, wBefore, arBefore;
    logic        ackHigh, ackErr;
    logic [31:0] ackRdata;
    vector_t     v;

    //                 wren  addr      wdata          be    awD wD bD arD rD bresp  rresp  expAddr        strb  expRdata       err lat
    vectors[0] = '{1'b1, 16'h0000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8000_0000, 4'hF, 32'h0000_0000, 1'b0, 4};
    vectors[1] = '{1'b0, 16'h0008, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8000_0008, 4'h0, 32'h0000_FFFF, 1'b0, 4};
    vectors[2] = '{1'b0, 16'h0000, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8000_0000, 4'h0, 32'hDEADBEEF, 1'b0, 4};
    vectors[3] = '{1'b1, 16'h0013, 32'h12345678, 4'h3, 0, 3, 0, 0, 0, 2'b00, 2'b00, 32'h8000_0010, 4'h3, 32'hDEADBEEF, 1'b0, 7};
    vectors[4] = '{1'b1, 16'h0011, 32'hAAAA1111, 4'hC, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h8000_0010, 4'hC, 32'hDEADBEEF, 1'b0, 7};
    vectors[5] = '{1'b0, 16'h0010, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 2'b00, 32'h8000_0010, 4'h0, 32'hAAAA5678, 1'b0, 7};
    vectors[6] = '{1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, 0, 0, 2, 0, 0, 2'b00, 2'b00, 32'h8000_0004, 4'h0, 32'hAAAA5678, 1'b0, 6};
    vectors[7] = '{1'b1, 16'h000C, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h8000_000C, 4'hF, 32'hAAAA5678, 1'b1, 4};
    vectors[8] = '{1'b0, 16'h0004, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h8000_0004, 4'h0, 32'h1000_0001, 1'b1, 4};
    vectors[9] = '{1'b0, 16'h000C, 32'h0,        4'h0, 0, 0, 0, 0, 4, 2'b00, 2'b00, 32'h8000_000C, 4'h0, 32'h1000_0003, 1'b0, 8};

    awBeats = 0; wBeats = 0; arBeats = 0;
    {awDelay, wDelay, bDelay, arDelay, rDelay} = '0;
    bRespCfg = 2'b00; rRespCfg = 2'b00;
    regReq = 1'b0; regWren = 1'b0; regAddr = '0; regWdata = '0; regBe = '0;
    arst = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset reg_ack", regAck, 0);
    checkOutput("reset reg_err", regErr, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset timeout", timeout, 0);
    checkOutput("reset reg_rdata", regRdata, 0);
    checkOutput("reset awvalid", bus.awvalid, 0);
    checkOutput("reset wvalid", bus.wvalid, 0);
    checkOutput("reset arvalid", bus.arvalid, 0);
    checkOutput("reset awaddr", bus.awaddr, 0);
    arst = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    for (int i = 0; i < 10; i++) begin
      v = vectors[i];
      awBefore = awBeats; wBefore = wBeats; arBefore = arBeats;
      applyStimulus(v, lat, ackHigh, ackErr, ackRdata);
      checkOutput($sformatf("v%0d ack seen", i), ackHigh, 1);
      checkOutput($sformatf("v%0d latency", i), lat, v.expLat);
      checkOutput($sformatf("v%0d reg_err", i), ackErr, v.expErr);
      checkOutput($sformatf("v%0d reg_rdata", i), ackRdata, v.expRdata);
      checkOutput($sformatf("v%0d busy in ack cycle", i), busy, 1);
      if (v.wren) begin
        checkOutput($sformatf("v%0d awaddr", i), lastAwAddr, v.expAddr);
        checkOutput($sformatf("v%0d wstrb", i), lastWStrb, v.expStrb);
        checkOutput($sformatf("v%0d aw beats", i), awBeats - awBefore, 1);
        checkOutput($sformatf("v%0d w beats", i), wBeats - wBefore, 1);
        checkOutput($sformatf("v%0d ar beats", i), arBeats - arBefore, 0);
      end else begin
        checkOutput($sformatf("v%0d araddr", i), lastArAddr, v.expAddr);
        checkOutput($sformatf("v%0d ar beats", i), arBeats - arBefore, 1);
        checkOutput($sformatf("v%0d aw beats", i), awBeats - awBefore, 0);
      end
      @(posedge aclk); #1;
      checkOutput($sformatf("v%0d ack one cycle", i), regAck, 0);
      checkOutput($sformatf("v%0d busy after ack", i), busy, 0);
    end

    // A second command while busy must vanish: one ack, no AR beat.
    {awDelay, wDelay, arDelay, rDelay} = '0;
    bDelay = 3; bRespCfg = 2'b00;
    awBefore = awBeats; arBefore = arBeats;
    regWren = 1'b1; regAddr = 16'h0014; regWdata = 32'h0000_0055; regBe = 4'hF;
    regReq = 1'b1;
    @(posedge aclk); #1;
    regReq = 1'b0;
    checkOutput("busy cycle after req", busy, 1);
    @(posedge aclk); #1;
    regWren = 1'b0; regAddr = 16'h0008; regReq = 1'b1;
    @(posedge aclk); #1;
    regReq = 1'b0;
    ackCount = 0;
    repeat (20) begin
      if (regAck) ackCount++;
      @(posedge aclk); #1;
    end
    checkOutput("busy req ack count", ackCount, 1);
    checkOutput("busy req aw beats", awBeats - awBefore, 1);
    checkOutput("busy req ar beats", arBeats - arBefore, 0);

    // Withheld B response: watchdog flags after TIMEOUT waiting cycles, ack still follows bvalid.
    bDelay = 1100;
    regWren = 1'b1; regAddr = 16'h0018; regWdata = 32'h0000_0077; regBe = 4'hF;
    regReq = 1'b1;
    @(posedge aclk); #1;
    regReq = 1'b0;
    n = 0;
    while (!bus.bready && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("timeout bready reached", bus.bready, 1);
    repeat (TIMEOUT - 1) @(posedge aclk);
    #1;
    checkOutput("timeout not yet set", timeout, 0);
    @(posedge aclk); #1;
    checkOutput("timeout set at limit", timeout, 1);
    n = 0;
    while (!regAck && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("timeout txn still acked", regAck, 1);
    checkOutput("timeout txn err", regErr, 0);
    @(posedge aclk); #1;
    checkOutput("timeout sticky", timeout, 1);
    checkOutput("payload stability", stabViol, 0);

    // Reset while a read address is still waiting for arready.
    arDelay = 50; bDelay = 0;
    arBefore = arBeats;
    regWren = 1'b0; regAddr = 16'h0008;
    regReq = 1'b1;
    @(posedge aclk); #1;
    regReq = 1'b0;
    checkOutput("rd_req arvalid", bus.arvalid, 1);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("mid reset arvalid", bus.arvalid, 0);
    checkOutput("mid reset rready", bus.rready, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset timeout", timeout, 0);
    @(posedge aclk); #1;
    arst = 1'b0;
    arDelay = 0;
    ackCount = 0;
    repeat (10) begin
      if (regAck) ackCount++;
      @(posedge aclk); #1;
    end
    checkOutput("mid reset no ack", ackCount, 0);
    checkOutput("mid reset ar beats", arBeats - arBefore, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
